// File: rtl/z80_im2_intc.sv
// Z80 IM2 interrupt controller: edge-latched requests, fixed-priority nesting arbitration,
// nINT generation and vector supply during the interrupt-acknowledge cycle.
module z80_im2_intc #(
  parameter int unsigned NUM_SRC      = 8,
  parameter logic [7:0]  IO_BASE      = 8'h40,
  parameter logic [7:0]  VEC_BASE_RST = 8'hE0
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [7:0]         A,
  input  logic [7:0]         D_in,
  output logic [7:0]         D_out,
  output logic               D_oe,
  input  logic               nM1,
  input  logic               nIORQ,
  input  logic               nRD,
  input  logic               nWR,
  output logic               nINT
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] sync1, sync2, prev;
  logic [NUM_SRC-1:0] pending, mask, in_service;
  logic [3:0]         vec_hi;
  logic [7:0]         vector;
  logic               wr_prev;

  logic               inta, io_sel, wr_stb, eoi, take, valid;
  logic [7:0]         offset;
  logic [NUM_SRC-1:0] eligible, pend_clr, pend_next, is_tmp, is_next;
  logic [2:0]         winner, top_is;

  function automatic logic [2:0] low_idx(input logic [NUM_SRC-1:0] v);
    low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) low_idx = 3'(i);
    end
  endfunction

  // Bus decode, arbitration and next-state of the request bookkeeping
  always_comb begin
    inta     = ~nM1 & ~nIORQ;
    offset   = A - IO_BASE;
    io_sel   = ~nIORQ & nM1 & (offset < 8'd3);
    wr_stb   = io_sel & ~nWR & wr_prev;
    eoi      = wr_stb & (offset == 8'd2);
    eligible = pending & ~mask;
    winner   = low_idx(eligible);
    top_is   = low_idx(in_service);
    valid    = (eligible != '0) && ((in_service == '0) || (winner < top_is));
    take     = (state == REQ) & valid & inta;
    pend_clr = take ? (NUM_SRC'(1) << winner) : '0;
    pend_next = (pending & ~pend_clr) | (sync2 & ~prev);
    // EOI sees the level set by an acknowledge in the same cycle
    is_tmp   = in_service | pend_clr;
    is_next  = eoi ? (is_tmp & ~NUM_SRC'(is_tmp & NUM_SRC'(~is_tmp + NUM_SRC'(1)))) : is_tmp;
  end

  // Bus drive: register reads, acknowledged vector, or 0xFF for a spurious acknowledge
  always_comb begin
    D_oe  = 1'b0;
    D_out = 8'h00;
    if (nRESET) begin
      if (io_sel && !nRD) begin
        D_oe = 1'b1;
        case (offset[1:0])
          2'd0:    D_out = pending;
          2'd1:    D_out = mask;
          default: D_out = in_service;
        endcase
      end else if (state == ACK && !nIORQ) begin
        D_oe  = 1'b1;
        D_out = vector;
      end else if (state == IDLE && inta) begin
        D_oe  = 1'b1;
        D_out = 8'hFF;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      pending    <= '0;
      mask       <= '1;
      in_service <= '0;
      vec_hi     <= VEC_BASE_RST[7:4];
      wr_prev    <= 1'b0;
    end else begin
      sync1      <= irq_in;
      sync2      <= sync1;
      prev       <= sync2;
      pending    <= pend_next;
      in_service <= is_next;
      wr_prev    <= nWR;
      if (wr_stb && offset == 8'd0) vec_hi <= D_in[7:4];
      if (wr_stb && offset == 8'd1) mask   <= D_in;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state  <= IDLE;
      nINT   <= 1'b1;
      vector <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            state <= REQ;
            nINT  <= 1'b0;
          end
        end
        REQ: begin
          if (!valid) begin
            state <= IDLE;
            nINT  <= 1'b1;
          end else if (inta) begin
            state  <= ACK;
            nINT   <= 1'b1;
            vector <= {vec_hi, winner, 1'b0};
          end
        end
        ACK: begin
          if (nIORQ) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          nINT  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z80_im2_intc.sv
// Directed bench for z80_im2_intc: bus-level stimulus with hand-computed expectations.
module tb_z80_im2_intc;

  logic       CLK = 1'b0;
  logic       nRESET;
  logic [7:0] irq_in;
  logic [7:0] A, D_in, D_out;
  logic       D_oe, nM1, nIORQ, nRD, nWR, nINT;

  int unsigned n_total  = 0;
  int unsigned n_passed = 0;

  localparam logic [7:0] BASE = 8'h40;

  z80_im2_intc dut (
    .CLK(CLK), .nRESET(nRESET), .irq_in(irq_in), .A(A), .D_in(D_in),
    .D_out(D_out), .D_oe(D_oe), .nM1(nM1), .nIORQ(nIORQ), .nRD(nRD),
    .nWR(nWR), .nINT(nINT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
    A = addr; D_in = data; nIORQ = 1'b0; nWR = 1'b0;
    tick();
    tick();
    nWR = 1'b1; nIORQ = 1'b1;
    tick();
  endtask

  task automatic io_read(input logic [7:0] addr, output logic [7:0] data, output logic oe);
    A = addr; nIORQ = 1'b0; nRD = 1'b0;
    #1;
    data = D_out; oe = D_oe;
    nRD = 1'b1; nIORQ = 1'b1;
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    logic       oe;
    io_read(addr, d, oe);
    check({tag, "_oe"}, {7'b0, oe}, 8'h01);
    check(tag, d, exp);
  endtask

  task automatic inta(output logic [7:0] v, output logic oe);
    nM1 = 1'b0; nIORQ = 1'b0;
    tick();
    v = D_out; oe = D_oe;
    nM1 = 1'b1; nIORQ = 1'b1;
    tick();
  endtask

  task automatic inta_chk(input string tag, input logic [7:0] exp);
    logic [7:0] v;
    logic       oe;
    inta(v, oe);
    check({tag, "_oe"}, {7'b0, oe}, 8'h01);
    check(tag, v, exp);
    check({tag, "_nint"}, {7'b0, nINT}, 8'h01);
  endtask

  task automatic pulse(input logic [7:0] bits);
    irq_in = bits;
    tick();
    tick();
    tick();
    irq_in = 8'h00;
  endtask

  initial begin
    logic [7:0] d;
    logic       oe;
    nRESET = 1'b0; irq_in = 8'h00; A = 8'h00; D_in = 8'h00;
    nM1 = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    tick(); tick();
    check("rst_nint", {7'b0, nINT}, 8'h01);
    check("rst_doe", {7'b0, D_oe}, 8'h00);
    check("rst_dout", D_out, 8'h00);
    nRESET = 1'b1;
    tick();

    // Register map after reset
    read_chk("rst_mask", BASE + 8'd1, 8'hFF);
    read_chk("rst_pend", BASE, 8'h00);
    read_chk("rst_isr", BASE + 8'd2, 8'h00);
    io_read(BASE + 8'd3, d, oe);
    check("unmapped_oe", {7'b0, oe}, 8'h00);
    io_write(BASE + 8'd1, 8'h00);
    read_chk("mask_wr", BASE + 8'd1, 8'h00);

    // Single source 3: pending after 3 edges, nINT one edge later
    pulse(8'h08);
    read_chk("t1_pend", BASE, 8'h08);
    check("t1_nint_pre", {7'b0, nINT}, 8'h01);
    tick();
    check("t1_nint", {7'b0, nINT}, 8'h00);
    inta_chk("t1_vec", 8'hE6);
    read_chk("t1_isr", BASE + 8'd2, 8'h08);
    read_chk("t1_pend_clr", BASE, 8'h00);
    io_write(BASE + 8'd2, 8'h00);
    read_chk("t1_eoi", BASE + 8'd2, 8'h00);

    // Sources 5 and 1 together: 1 first, 5 waits for EOI
    pulse(8'h22);
    tick();
    check("t2_nint", {7'b0, nINT}, 8'h00);
    inta_chk("t2_vec1", 8'hE2);
    read_chk("t2_pend", BASE, 8'h20);
    tick(); tick(); tick();
    check("t2_hold", {7'b0, nINT}, 8'h01);
    io_write(BASE + 8'd2, 8'h00);
    check("t2_reassert", {7'b0, nINT}, 8'h00);
    inta_chk("t2_vec5", 8'hEA);
    io_write(BASE + 8'd2, 8'h00);

    // Nesting against in-service level 4
    pulse(8'h10);
    tick();
    inta_chk("t3_vec4", 8'hE8);
    read_chk("t3_isr10", BASE + 8'd2, 8'h10);
    pulse(8'h40);
    tick(); tick(); tick();
    check("t3_blocked", {7'b0, nINT}, 8'h01);
    pulse(8'h04);
    tick();
    check("t3_nest_nint", {7'b0, nINT}, 8'h00);
    inta_chk("t3_vec2", 8'hE4);
    read_chk("t3_isr14", BASE + 8'd2, 8'h14);
    io_write(BASE + 8'd2, 8'h00);
    read_chk("t3_eoi_low", BASE + 8'd2, 8'h10);
    check("t3_still_blk", {7'b0, nINT}, 8'h01);
    io_write(BASE + 8'd2, 8'h00);
    check("t3_src6_nint", {7'b0, nINT}, 8'h00);
    inta_chk("t3_vec6", 8'hEC);
    io_write(BASE + 8'd2, 8'h00);

    // Mask withdrawal before acknowledge
    pulse(8'h01);
    tick();
    check("t4_nint", {7'b0, nINT}, 8'h00);
    io_write(BASE + 8'd1, 8'hFF);
    check("t4_withdrawn", {7'b0, nINT}, 8'h01);
    read_chk("t4_pend", BASE, 8'h01);
    io_write(BASE + 8'd1, 8'h00);
    check("t4_reassert", {7'b0, nINT}, 8'h00);
    inta_chk("t4_vec0", 8'hE0);
    io_write(BASE + 8'd2, 8'h00);

    // Vector base write; register 0 reads back pending
    io_write(BASE, 8'h37);
    read_chk("t5_rd0", BASE, 8'h00);
    pulse(8'h80);
    read_chk("t5_pend", BASE, 8'h80);
    tick();
    inta_chk("t5_vec7", 8'h3E);
    io_write(BASE + 8'd2, 8'h00);

    // Spurious acknowledge in IDLE
    nM1 = 1'b0; nIORQ = 1'b0;
    #1;
    check("t6_spur_oe", {7'b0, D_oe}, 8'h01);
    check("t6_spur_d", D_out, 8'hFF);
    tick();
    check("t6_spur_d2", D_out, 8'hFF);
    check("t6_spur_nint", {7'b0, nINT}, 8'h01);
    nM1 = 1'b1; nIORQ = 1'b1;
    tick();
    read_chk("t6_mask", BASE + 8'd1, 8'h00);
    read_chk("t6_isr", BASE + 8'd2, 8'h00);

    // Reset asserted during ACK
    pulse(8'h08);
    tick();
    check("t7_nint", {7'b0, nINT}, 8'h00);
    nM1 = 1'b0; nIORQ = 1'b0;
    tick();
    check("t7_ack_oe", {7'b0, D_oe}, 8'h01);
    check("t7_ack_d", D_out, 8'h36);
    nRESET = 1'b0;
    #1;
    check("t7_rst_oe", {7'b0, D_oe}, 8'h00);
    check("t7_rst_nint", {7'b0, nINT}, 8'h01);
    check("t7_rst_d", D_out, 8'h00);
    nM1 = 1'b1; nIORQ = 1'b1;
    tick();
    nRESET = 1'b1;
    tick();
    read_chk("t7_mask", BASE + 8'd1, 8'hFF);
    read_chk("t7_pend", BASE, 8'h00);
    read_chk("t7_isr", BASE + 8'd2, 8'h00);
    io_write(BASE + 8'd1, 8'h00);
    pulse(8'h04);
    tick();
    inta_chk("t7_vecbase", 8'hE4);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/z80_im2_intc.md
Name: z80_im2_intc

Overview:
- IM2 interrupt controller that shares the Z80 nINT line among NUM_SRC peripheral requesters.
- Latches rising-edge requests and arbitrates them by fixed priority (index 0 highest), nesting against in-service levels.
- Drives nINT and supplies the IM2 vector byte during the interrupt-acknowledge cycle (nM1 and nIORQ both low).
- Configured and cleared through three Z80 IO ports; sits on the Z80 bus beside the ram and io models.

Parameters:
NUM_SRC, 8, number of request inputs (fixed at 8; vector encodes a 3-bit index)
IO_BASE, 8'h40, low-byte IO address of register 0; registers occupy IO_BASE..IO_BASE+2
VEC_BASE_RST, 8'hE0, reset value of the vector base register

Ports:
CLK  in  1  system clock; all state on rising edge
nRESET  in  1  asynchronous active-low reset
irq_in  in  NUM_SRC  asynchronous request lines, active-high, rising-edge sensitive
A  in  8  Z80 address low byte
D_in  in  8  Z80 data bus, input side
D_out  out  8  data driven onto Z80 bus
D_oe  out  1  high when D_out must drive the bus
nM1  in  1  Z80 M1, active-low
nIORQ  in  1  Z80 IORQ, active-low
nRD  in  1  Z80 RD, active-low
nWR  in  1  Z80 WR, active-low
nINT  out  1  interrupt request to Z80, active-low, registered

Behaviour:
- Reset (async on nRESET low): nINT=1, D_oe=0, D_out=8'h00, pending=0, mask=8'hFF (all masked), in_service=0, vec_base=VEC_BASE_RST, FSM=IDLE, sync/edge flops=0.
- Input path: irq_in passes sync1 -> sync2 -> prev. pending[i] sets on the cycle sync2[i]=1 and prev[i]=0. The rising edge of irq_in is registered in pending 3 CLK edges later.
- Simultaneous set and clear of the same pending bit: set wins.
- Eligibility:
  - Define eligible = pending & ~mask.
  - winner = lowest set index of eligible.
  - top_is = lowest set index of in_service (NONE if zero).
  - A request is valid when eligible!=0 and (top_is==NONE or winner<top_is).
- IO decode: io_sel when nIORQ=0, nM1=1 and A is in IO_BASE..+2.
  - Write: committed once, on the first CLK where nWR=0 and nWR was 1 on the previous CLK (registered nWR history).
  - Read: D_oe = io_sel & ~nRD, combinational. D_out = selected register.
- Register map:
  - +0 write: vec_base <= D_in & 8'hF0. +0 read: pending.
  - +1 read/write: mask (1 = masked).
  - +2 write: EOI, clears the lowest set bit of in_service (no-op if zero); data ignored. +2 read: in_service.
  - Unmapped addresses: no drive, no effect.
- FSM:
  - IDLE: nINT=1. If request valid -> REQ; nINT goes 0 on the next edge.
  - REQ: nINT=0.
    - If the request becomes not valid (mask write, EOI changing nesting) before acknowledge: nINT=1 and -> IDLE.
    - On the first CLK with nM1=0 and nIORQ=0 (INTA): snapshot winner w. Set in_service[w], clear pending[w], nINT=1, latch vector={vec_base[7:4], w[2:0], 1'b0} -> ACK.
  - ACK: D_oe=1 and D_out=latched vector while nIORQ=0. First CLK with nIORQ=1: D_oe=0 -> IDLE.
- INTA seen in IDLE (spurious): D_oe=1, D_out=8'hFF while nIORQ=0; no state change.
- Priority is decided at the INTA snapshot, not at nINT assertion. A higher request arriving during REQ is the one acknowledged.
- New edges during ACK set pending normally. Re-evaluation occurs in IDLE.
- Only one EOI per write cycle. EOI during ACK is applied after the in_service set of the same acknowledge.
- nRESET low mid-cycle: all state clears immediately, and nINT and D_oe release within the same delta.

Test Plan:
- Reset, mask=8'h00, pulse irq_in[3] -> pending=8'h08 after 3 edges, nINT=0 one edge later. INTA -> D_out=8'hE6, in_service=8'h08, pending=8'h00, nINT=1.
- irq_in[5] and irq_in[1] pulse together -> single nINT. INTA vector 8'hE2, pending=8'h20 remains. nINT stays 1 until EOI. After EOI (in_service=0), nINT reasserts and the next INTA gives 8'hEA.
- Nesting: in_service=8'h10 (level 4). Edge on irq_in[6] -> no nINT. Edge on irq_in[2] -> nINT=0, vector 8'hE4, in_service=8'h14.
- Mask withdrawal: nINT low for source 0, IO write 8'hFF to IO_BASE+1 before INTA -> nINT=1 within 2 CLK, pending[0] still 1. Unmask -> nINT reasserts.
- Register access: write 8'h37 to IO_BASE+0 -> read returns pending, and a later vector for source 7 = 8'h3E. Read IO_BASE+1 after reset = 8'hFF. Read IO_BASE+3 -> D_oe=0.
- Spurious INTA in IDLE -> D_out=8'hFF, no register change. Assert nRESET during ACK -> D_oe=0 and nINT=1 immediately, and all registers return to reset values.
